seg_capture: RTL and testbench

Decodes the time-multiplexed seven-segment display bus (`anode`, `cathode`, `dp`) driven by the lab top into a stable per-digit snapshot for probe readback. It is the receiving end of the display scan: it watches the scanned digit strobes, waits until a digit has settled, latches its segment pattern, and flags when a complete frame has been seen. It sits between the lab top's display outputs and the VIO probe inputs, so the remote host reads whole digits instead of raw scan-phase samples.

---
 rtl/seg_capture.sv | 213 +++++++++++++++++++++
 tb/tb_seg_capture.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_capture.sv
// seg_capture: decodes a time-multiplexed seven-segment scan bus into a
// stable per-digit snapshot, a frame-complete pulse and a frame counter.
// A digit is latched only after its strobe/segment sample has been steady
// for STABLE_CYCLES samples. Each settled value is latched at most once.
// Optional feature macro: SEG_CAPTURE_SYNC_EN puts a 2-flop synchroniser
// on anode/cathode/dp for asynchronous sources.
module seg_capture #(
    parameter int NUM_DIGITS       = 8,
    parameter int STABLE_CYCLES    = 16,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS-1:0]   anode,
    input  logic [6:0]              cathode,
    input  logic                    dp,
    output logic [8*NUM_DIGITS-1:0] seg_frame,
    output logic [NUM_DIGITS-1:0]   digit_seen,
    output logic                    frame_valid,
    output logic [15:0]             frame_count,
    output logic                    overlap_err
);

    localparam int SW = NUM_DIGITS + 8;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [0:0] {SETTLE = 1'b0, HELD = 1'b1} state_t;
    typedef enum logic [1:0] {STB_NONE = 2'b00, STB_ONE = 2'b01, STB_MULTI = 2'b10} stb_t;

    // Classify a normalised strobe vector: blank, exactly one digit, or overlap.
    function automatic stb_t strobe_class(input logic [NUM_DIGITS-1:0] v);
        if (v == {NUM_DIGITS{1'b0}}) begin
            return STB_NONE;
        end else if ((v & (v - NUM_DIGITS'(1))) == {NUM_DIGITS{1'b0}}) begin
            return STB_ONE;
        end else begin
            return STB_MULTI;
        end
    endfunction

    logic [NUM_DIGITS-1:0] anode_s;
    logic [6:0]            cathode_s;
    logic                  dp_s;

`ifdef SEG_CAPTURE_SYNC_EN
    logic [SW-1:0] sync1_r;
    logic [SW-1:0] sync2_r;

    // Two-flop synchroniser for display inputs from another clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= {SW{1'b0}};
            sync2_r <= {SW{1'b0}};
        end else begin
            sync1_r <= {anode, cathode, dp};
            sync2_r <= sync1_r;
        end
    end

    assign {anode_s, cathode_s, dp_s} = sync2_r;
`else
    assign anode_s   = anode;
    assign cathode_s = cathode;
    assign dp_s      = dp;
`endif

    // Normalised view: strobe bit high = digit selected, segment bit high = lit.
    logic [NUM_DIGITS-1:0] a_act_s;
    logic [7:0]            seg_s;

    assign a_act_s = (ANODE_ACTIVE_LOW != 0) ? ~anode_s : anode_s;
    assign seg_s   = ~{dp_s, cathode_s};

    logic [SW-1:0] s_cur_r;
    logic [SW-1:0] s_prev_r;

    // Sample pipeline: current sample and the one before it for change detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_cur_r  <= {SW{1'b0}};
            s_prev_r <= {SW{1'b0}};
        end else begin
            s_cur_r  <= {a_act_s, seg_s};
            s_prev_r <= s_cur_r;
        end
    end

    state_t        state_r;
    state_t        state_n;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_n;
    logic          latch_s;
    logic          changed_s;

    assign changed_s = (s_cur_r != s_prev_r);

    // Settle FSM state and stability counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= SETTLE;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
        end
    end

    // Next-state: count steady samples in SETTLE, latch once, then wait in HELD.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        latch_s = 1'b0;
        case (state_r)
            SETTLE: begin
                if (changed_s) begin
                    cnt_n = {CW{1'b0}};
                end else begin
                    cnt_n = cnt_r + CW'(1);
                    if (cnt_n == CNT_LAST) begin
                        latch_s = 1'b1;
                        state_n = HELD;
                    end else begin
                        state_n = SETTLE;
                    end
                end
            end
            HELD: begin
                if (changed_s) begin
                    cnt_n   = {CW{1'b0}};
                    state_n = SETTLE;
                end else begin
                    state_n = HELD;
                end
            end
            default: begin
                state_n = SETTLE;
                cnt_n   = {CW{1'b0}};
            end
        endcase
    end

    logic [NUM_DIGITS-1:0]   cur_stb_s;
    logic [7:0]              cur_seg_s;
    logic [NUM_DIGITS-1:0]   seen_or_s;
    logic [8*NUM_DIGITS-1:0] seg_frame_n;
    logic [NUM_DIGITS-1:0]   digit_seen_n;
    logic                    frame_valid_n;
    logic [15:0]             frame_count_n;
    logic                    overlap_err_n;

    assign cur_stb_s = s_cur_r[SW-1:8];
    assign cur_seg_s = s_cur_r[7:0];

    // Latch action: store the digit byte, track seen digits, detect frame completion.
    always_comb begin
        seg_frame_n   = seg_frame;
        digit_seen_n  = digit_seen;
        frame_valid_n = 1'b0;
        frame_count_n = frame_count;
        overlap_err_n = overlap_err;
        seen_or_s     = digit_seen | cur_stb_s;
        if (latch_s) begin
            case (strobe_class(cur_stb_s))
                STB_ONE: begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (cur_stb_s[i]) begin
                            seg_frame_n[8*i +: 8] = cur_seg_s;
                        end else begin
                            seg_frame_n[8*i +: 8] = seg_frame[8*i +: 8];
                        end
                    end
                    if (&seen_or_s) begin
                        digit_seen_n  = {NUM_DIGITS{1'b0}};
                        frame_valid_n = 1'b1;
                        frame_count_n = frame_count + 16'd1;
                    end else begin
                        digit_seen_n  = seen_or_s;
                    end
                end
                STB_MULTI: begin
                    overlap_err_n = 1'b1;
                end
                STB_NONE: begin
                    overlap_err_n = overlap_err;
                end
                default: begin
                    overlap_err_n = overlap_err;
                end
            endcase
        end else begin
            frame_valid_n = 1'b0;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_frame   <= {(8*NUM_DIGITS){1'b0}};
            digit_seen  <= {NUM_DIGITS{1'b0}};
            frame_valid <= 1'b0;
            frame_count <= 16'd0;
            overlap_err <= 1'b0;
        end else begin
            seg_frame   <= seg_frame_n;
            digit_seen  <= digit_seen_n;
            frame_valid <= frame_valid_n;
            frame_count <= frame_count_n;
            overlap_err <= overlap_err_n;
        end
    end

endmodule

// File: tb/tb_seg_capture.sv
// Self-checking bench for seg_capture (NUM_DIGITS=8, STABLE_CYCLES=4,
// active-low anodes). A run-length reference model predicts every output
// after every clock edge; directed checks cover the scan scenarios.
module tb_seg_capture;

    localparam int ND = 8;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [ND-1:0] anode = 8'hFF;
    logic [6:0]    cathode = 7'h7F;
    logic          dp = 1'b1;
    logic [8*ND-1:0] seg_frame;
    logic [ND-1:0]   digit_seen;
    logic            frame_valid;
    logic [15:0]     frame_count;
    logic            overlap_err;

    always #5 clk = ~clk;

    seg_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC), .ANODE_ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .anode(anode), .cathode(cathode), .dp(dp),
        .seg_frame(seg_frame), .digit_seen(digit_seen), .frame_valid(frame_valid),
        .frame_count(frame_count), .overlap_err(overlap_err)
    );

    int n_vec = 0;
    int n_err = 0;
    int fv_cnt = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: latch happens at the edge after a sample value has been
    // seen on exactly SC consecutive edges; one latch per steady run.
    bit [7:0]  m_frame [ND];
    bit [7:0]  m_seen;
    bit        m_fv;
    bit [15:0] m_cnt;
    bit        m_ovf;
    bit [15:0] m_last;
    int        m_run;

    function automatic logic [63:0] m_flat();
        logic [63:0] r;
        for (int i = 0; i < ND; i++) r[8*i +: 8] = m_frame[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ND; i++) m_frame[i] = 8'h00;
        m_seen = 8'h00; m_fv = 1'b0; m_cnt = 16'h0000; m_ovf = 1'b0;
        m_last = {8'hFF, 7'h7F, 1'b1};
        m_run  = 1;
    endtask

    task automatic model_latch(input logic [15:0] smp);
        logic [7:0] act;
        logic [7:0] sg;
        act = ~smp[15:8];
        sg  = ~{smp[0], smp[7:1]};
        if ($countones(act) == 1) begin
            m_frame[$clog2(act)] = sg;
            m_seen = m_seen | act;
            if (m_seen == 8'hFF) begin
                m_seen = 8'h00;
                m_fv   = 1'b1;
                m_cnt  = m_cnt + 16'd1;
            end
        end else if ($countones(act) > 1) begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic model_edge();
        logic [15:0] cur;
        m_fv = 1'b0;
        if (m_run == SC) model_latch(m_last);
        cur = {anode, cathode, dp};
        if (cur == m_last) begin
            if (m_run <= SC) m_run++;
        end else begin
            m_last = cur;
            m_run  = 1;
        end
    endtask

    task automatic check_all();
        check_val("frame_valid", {63'd0, frame_valid}, {63'd0, m_fv});
        check_val("seg_frame", seg_frame, m_flat());
        check_val("digit_seen", {56'd0, digit_seen}, {56'd0, m_seen});
        check_val("frame_count", {48'd0, frame_count}, {48'd0, m_cnt});
        check_val("overlap_err", {63'd0, overlap_err}, {63'd0, m_ovf});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        if (frame_valid === 1'b1) fv_cnt++;
        check_all();
    endtask

    task automatic drive(input logic [7:0] a, input logic [6:0] c, input logic d, input int n);
        anode = a; cathode = c; dp = d;
        repeat (n) step();
    endtask

    task automatic drive_digit(input int i, input int n);
        logic [7:0] a;
        logic [6:0] c;
        a = ~(8'h01 << i);
        c = ~(7'h01 << (i % 7));
        drive(a, c, 1'b1, n);
    endtask

    task automatic do_reset();
        anode = 8'hFF; cathode = 7'h7F; dp = 1'b1;
        #2 rst = 1'b1;
        #1;
        check_val("rst_seg_frame", seg_frame, 64'd0);
        check_val("rst_digit_seen", {56'd0, digit_seen}, 64'd0);
        check_val("rst_frame_valid", {63'd0, frame_valid}, 64'd0);
        check_val("rst_frame_count", {48'd0, frame_count}, 64'd0);
        check_val("rst_overlap_err", {63'd0, overlap_err}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    logic [63:0] scan_img;
    logic [7:0]  e8;
    int          fv_before;

    initial begin
        do_reset();

        // Idle blank bus: no frame activity.
        fv_before = fv_cnt;
        drive(8'hFF, 7'h7F, 1'b1, 50);
        check_val("idle_no_fv", 64'(fv_cnt - fv_before), 64'd0);

        // Full scan with directed pulse timing on the last digit.
        fv_before = fv_cnt;
        for (int i = 0; i < 7; i++) drive_digit(i, 10);
        drive_digit(7, SC);
        check_val("fv_early", {63'd0, frame_valid}, 64'd0);
        drive_digit(7, 1);
        check_val("fv_timing", {63'd0, frame_valid}, 64'd1);
        drive_digit(7, 5);
        check_val("scan_fv_pulses", 64'(fv_cnt - fv_before), 64'd1);
        check_val("scan_count", {48'd0, frame_count}, 64'd1);
        check_val("scan_seen", {56'd0, digit_seen}, 64'd0);
        for (int i = 0; i < ND; i++) begin
            e8 = 8'h01 << (i % 7);
            scan_img[8*i +: 8] = e8;
            check_val("scan_byte", {56'd0, seg_frame[8*i +: 8]}, {56'd0, e8});
        end

        // Glitch on digit 3 shorter than the settle window.
        drive_digit(2, 10);
        drive(8'hF7, 7'h00, 1'b0, 3);
        drive_digit(2, 10);
        check_val("glitch_byte3", {56'd0, seg_frame[31:24]}, 64'h08);
        check_val("glitch_seen", {56'd0, digit_seen}, 64'h04);

        // Overlapping strobes.
        drive(8'hFC, 7'h00, 1'b0, 10);
        check_val("ovl_err", {63'd0, overlap_err}, 64'd1);
        check_val("ovl_frame", seg_frame, scan_img);
        check_val("ovl_seen", {56'd0, digit_seen}, 64'h04);

        // Long blanking gap mid-scan, then completion.
        for (int i = 0; i < 4; i++) drive_digit(i, 10);
        fv_before = fv_cnt;
        drive(8'hFF, 7'h7F, 1'b1, 100);
        check_val("blank_no_fv", 64'(fv_cnt - fv_before), 64'd0);
        check_val("blank_frame", seg_frame, scan_img);
        for (int i = 4; i < ND; i++) drive_digit(i, 10);
        check_val("blank_count", {48'd0, frame_count}, 64'd2);
        check_val("ovl_sticky", {63'd0, overlap_err}, 64'd1);

        // Reset mid-scan discards partial progress.
        for (int i = 0; i < 5; i++) drive_digit(i, 10);
        do_reset();
        fv_before = fv_cnt;
        for (int i = 5; i < ND; i++) drive_digit(i, 10);
        check_val("partial_no_fv", 64'(fv_cnt - fv_before), 64'd0);
        for (int i = 0; i < ND; i++) drive_digit(i, 10);
        check_val("post_rst_count", {48'd0, frame_count}, 64'd1);

        // Randomised bus traffic against the model.
        for (int k = 0; k < 300; k++) begin
            int          kind;
            int          hold;
            logic [7:0]  a;
            logic [7:0]  r8;
            kind = $urandom_range(0, 9);
            hold = $urandom_range(1, 2 * SC + 2);
            r8   = 8'($urandom);
            if (kind <= 6) begin
                a = ~(8'h01 << $urandom_range(0, ND - 1));
            end else if (kind == 7) begin
                a = 8'hFF;
            end else if (kind == 8) begin
                a = ~(r8 | 8'h81);
            end else begin
                a = r8;
            end
            drive(a, 7'($urandom), 1'($urandom), hold);
            if ($urandom_range(0, 59) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
